// File: rtl/gray_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gray_pkg: default width and Gray/binary conversion helpers.       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package gray_pkg;

  localparam int unsigned c_DEFAULT_WIDTH = 4;

  // Operands are zero-extended to 32 bits; the low WIDTH bits of the result stay valid.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray2bin_conv.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gray2bin_conv: combinational Gray-to-binary converter.            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Each binary bit is the parity of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[WIDTH-1:i];
  end

endmodule
`default_nettype wire

// File: rtl/gray_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gray_counter: up/down binary counter with registered Gray output. |
// | GRAY_COUNTER_SAT_EN selects saturating instead of wrapping count. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_q,
  output logic [WIDTH-1:0] bin_q,
  output logic             tc
);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_bin_nxt;
  logic             w_at_top;
  logic             w_at_bot;

  gray2bin_conv #(.WIDTH(WIDTH)) u_conv (
    .i_gray (load_gray),
    .o_bin  (w_load_bin)
  );

  assign w_at_top = &r_bin;
  assign w_at_bot = ~|r_bin;

  always_comb begin
    w_bin_nxt = r_bin;
    if (load) begin
      w_bin_nxt = w_load_bin;
    end else if (en) begin
`ifdef GRAY_COUNTER_SAT_EN
      if (up && !w_at_top) begin
        w_bin_nxt = r_bin + WIDTH'(1);
      end else if (!up && !w_at_bot) begin
        w_bin_nxt = r_bin - WIDTH'(1);
      end
`else
      w_bin_nxt = up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
`endif
    end
  end

  // Gray is derived from the next binary value so both outputs update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= WIDTH'(bin2gray(32'(w_bin_nxt)));
    end
  end

  assign gray_q = r_gray;
  assign bin_q  = r_bin;
  assign tc     = up ? w_at_top : w_at_bot;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_gray_counter: scoreboard bench for gray_counter (4 and 8 bit). |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_gray_counter;

  typedef struct {
    logic [3:0] g;
    logic [3:0] b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] load_gray = 4'd0;
  logic [3:0] gray_q, bin_q;
  logic       tc;

  logic       en8 = 1'b0, up8 = 1'b1, load8 = 1'b0;
  logic [7:0] lg8 = 8'd0;
  logic [7:0] gray8, bin8;
  logic       tc8;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [3:0] m_bin = 4'd0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_gray(load_gray), .gray_q(gray_q), .bin_q(bin_q), .tc(tc)
  );

  gray_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .up(up8), .load(load8),
    .load_gray(lg8), .gray_q(gray8), .bin_q(bin8), .tc(tc8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] g2b4(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Drive one cycle of stimulus, push the model's expectation, compare after the edge.
  task automatic step(input logic e, input logic u, input logic l, input logic [3:0] lg);
    exp_t x;
    en = e; up = u; load = l; load_gray = lg;
    if (rst_n) begin
      if (l) m_bin = g2b4(lg);
      else if (e) begin
`ifdef GRAY_COUNTER_SAT_EN
        if (u && m_bin != 4'hF) m_bin = m_bin + 4'd1;
        else if (!u && m_bin != 4'h0) m_bin = m_bin - 4'd1;
`else
        m_bin = u ? m_bin + 4'd1 : m_bin - 4'd1;
`endif
      end
    end
    x.b = m_bin;
    x.g = m_bin ^ (m_bin >> 1);
    sb.push_back(x);
    @(posedge clk); #1;
    x = sb.pop_front();
    check("gray_q", 32'(gray_q), 32'(x.g));
    check("bin_q", 32'(bin_q), 32'(x.b));
  endtask

  task automatic check_tc(input string tag);
    logic e;
    e = up ? (m_bin == 4'hF) : (m_bin == 4'h0);
    check(tag, 32'(tc), 32'(e));
  endtask

  initial begin
    logic [3:0] tbl [0:16];
    logic [3:0] prev, e4;
    logic [7:0] e8;
    int cnt;
    tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
            4'b0000};

    // Reset state, with strobes ignored during reset.
    #1;
    check("rst_gray", 32'(gray_q), 32'd0);
    check("rst_bin", 32'(bin_q), 32'd0);
    check_tc("rst_tc_up");
    up = 1'b0; #1;
    check_tc("rst_tc_dn");
    step(1'b1, 1'b1, 1'b1, 4'b1111);
    rst_n = 1'b1;

    // Up count through wrap-around.
    check("up_start", 32'(gray_q), 32'(tbl[0]));
    for (int i = 0; i < 16; i++) begin
      up = 1'b1; #1;
      check("up_tc", 32'(tc), 32'(gray_q == 4'b1000));
      prev = gray_q;
      step(1'b1, 1'b1, 1'b0, 4'd0);
      e4 = tbl[i+1];
`ifdef GRAY_COUNTER_SAT_EN
      if (i == 15) e4 = 4'b1000;
      else check("up_hamming", 32'($countones(prev ^ gray_q)), 32'd1);
`else
      check("up_hamming", 32'($countones(prev ^ gray_q)), 32'd1);
`endif
      check("up_table", 32'(gray_q), 32'(e4));
    end

    // Asynchronous reset mid-count at gray 0110.
    step(1'b0, 1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 4'd0);
    check("mid_gray", 32'(gray_q), 32'b0110);
    #2 rst_n = 1'b0;
    m_bin = 4'd0;
    #1;
    check("async_gray", 32'(gray_q), 32'd0);
    check("async_bin", 32'(bin_q), 32'd0);
    check("async_tc", 32'(tc), 32'd0);
    step(1'b1, 1'b1, 1'b1, 4'b1010);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 4'd0);

    // Load, then load winning over enable.
    step(1'b0, 1'b1, 1'b1, 4'b1011);
    check("load_bin", 32'(bin_q), 32'b1101);
    step(1'b0, 1'b1, 1'b1, 4'b0001);
    step(1'b1, 1'b1, 1'b1, 4'b0100);
    check("prio_gray", 32'(gray_q), 32'b0100);
    check("prio_bin", 32'(bin_q), 32'b0111);

    // Down count from zero.
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    step(1'b1, 1'b0, 1'b0, 4'd0);
`ifdef GRAY_COUNTER_SAT_EN
    check("down_bin", 32'(bin_q), 32'b0000);
    check("down_tc", 32'(tc), 32'd1);
`else
    check("down_bin", 32'(bin_q), 32'b1111);
    check("down_gray", 32'(gray_q), 32'b1000);
`endif

    // Hold: direction change only moves tc.
    step(1'b0, 1'b1, 1'b0, 4'b0110);
    check_tc("hold_tc_up");
    up = 1'b0; #1;
    check_tc("hold_tc_dn");
    check("hold_bin", 32'(bin_q), 32'(m_bin));
    step(1'b0, 1'b0, 1'b0, 4'b0110);
    check_tc("hold_tc_dn2");
    step(1'b1, 1'b0, 1'b0, 4'd0);
    check_tc("after_step_tc");

    // 8-bit instance: 256 up steps against a counted reference.
    en8 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      cnt++;
`ifdef GRAY_COUNTER_SAT_EN
      e8 = (cnt > 255) ? 8'd255 : 8'(cnt);
`else
      e8 = 8'(cnt % 256);
`endif
      check("w8_bin", 32'(bin8), 32'(e8));
      check("w8_gray", 32'(gray8), 32'(e8 ^ (e8 >> 1)));
    end
    en8 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The block SHALL expose parameter: WIDTH, 4, counter/code width in bits (legal range 2..32).
REQ-002 The block SHALL expose port: clk  input  1  rising-edge clock.
REQ-003 The block SHALL expose port: rst_n  input  1  reset.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 The block SHALL expose port: en  input  1  count enable, one step per cycle while high.
REQ-006 The block SHALL expose port: up  input  1  direction (1 = increment, 0 = decrement).
REQ-007 The block SHALL expose port: load  input  1  synchronous load strobe.
REQ-008 The block SHALL expose port: load_gray  input  WIDTH  Gray-coded value to load.
REQ-009 The block SHALL expose port: gray_q  output  WIDTH  registered Gray-coded count.
REQ-010 The block SHALL expose port: bin_q  output  WIDTH  registered binary equivalent of gray_q.
REQ-011 The block SHALL expose port: tc  output  1  terminal-count flag.

Function
REQ-012 Internal state SHALL be a single WIDTH-bit binary register; gray_q SHALL equal bin_q XOR (bin_q >> 1) in every cycle, both registered on the same edge.
REQ-013 Priority per rising edge SHALL be: load > en > hold.
REQ-014 On load, bin_q SHALL take the Gray-to-binary conversion of load_gray (bit MSB copied, bit i = bit i+1 of result XOR load_gray[i]) and gray_q SHALL equal load_gray, visible one cycle later (latency 1).
REQ-015 On en with up=1, bin_q SHALL become bin_q+1 modulo 2^WIDTH; with up=0, bin_q-1 modulo 2^WIDTH.
REQ-016 Consecutive gray_q values during counting SHALL differ in exactly one bit, including across wrap-around.
REQ-017 tc SHALL be combinational from current state and up: high when up=1 and bin_q = all ones, or up=0 and bin_q = 0; low otherwise.
REQ-018 With en=0 and load=0, both outputs SHALL hold; changing up alone SHALL affect only tc.

Reset
REQ-019 When rst_n goes low, gray_q and bin_q SHALL become 0 immediately, without a clock edge.
REQ-020 While rst_n is low, load and en SHALL be ignored; tc SHALL reflect state 0 (high iff up=0).
REQ-021 First count or load SHALL occur on the first rising clk edge after rst_n returns high.

Configuration
REQ-022 Macro GRAY_COUNTER_SAT_EN defined: counting SHALL saturate: en with up=1 at all ones, or up=0 at 0, SHALL hold state; load unaffected.
REQ-023 Macro GRAY_COUNTER_SAT_EN undefined: counting SHALL wrap per REQ-015.

Structure
REQ-024 A shared package gray_pkg SHALL hold the default WIDTH constant and the bin-to-gray and gray-to-binary conversion functions.
REQ-025 Gray-to-binary conversion of load_gray SHALL be a separate parametrised combinational sub-module gray2bin_conv (WIDTH parameter), instantiated once.

Verification
REQ-026 Reset: hold rst_n low mid-count at gray_q=0110 -> gray_q=0000, bin_q=0000 before next clk edge; tc=0 with up=1.
REQ-027 Up count, WIDTH=4, en=1 for 17 cycles from 0 -> gray_q 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; Hamming distance 1 per step; tc high only at 1000.
REQ-028 Load load_gray=1011 -> next cycle gray_q=1011, bin_q=1101.
REQ-029 Down count from 0, en=1, up=0 -> without SAT_EN bin_q=1111, gray_q=1000; with SAT_EN state stays 0000, tc stays 1.
REQ-030 load=1 and en=1 same cycle with load_gray=0100 from state 0001 -> gray_q=0100, bin_q=0111 (no increment applied).
REQ-031 WIDTH=8 up count for 256 cycles -> bin_q matches cycle count mod 256 and gray_q matches reference bin-to-gray every cycle.
